// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the RV32I pipeline sequencing controller:
//   - FSM state encoding for the interrupt entry sequence
//   - register/word zero constants, write-enable, hold and flush levels
//   - load-instruction indication level
//   - reg_match(): nonzero source register equal to a destination register
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_IRQ_ENTER = 2'd1,
      ST_IRQ_JUMP  = 2'd2
   } pipe_state_e;

   localparam logic [4:0]  ZERO_REG      = 5'd0;
   localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
   localparam logic        WRITE_ENABLE  = 1'b1;
   localparam logic        WRITE_DISABLE = 1'b0;
   localparam logic        HOLD          = 1'b1;
   localparam logic        NO_HOLD       = 1'b0;
   localparam logic        FLUSH         = 1'b1;
   localparam logic        NO_FLUSH      = 1'b0;
   localparam logic        LOAD_YES      = 1'b1;

   // x0 is never a real dependency, so a zero source register never matches.
   function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
      return (rs != ZERO_REG) && (rs == rd);
   endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_hazard_detect
// Combinational load-use hazard compare between the load in EX and the
// operands being read in decode.
// Ports:
//   ex_is_load_i     in   instruction in EX is a load
//   ex_reg_we_i      in   EX instruction writes rd
//   ex_reg_waddr_i   in   EX rd
//   id_reg1_raddr_i  in   decode rs1 (0 = none)
//   id_reg2_raddr_i  in   decode rs2 (0 = none)
//   load_use_o       out  load-use hazard present
// -----------------------------------------------------------------------------
module pipe_ctrl_hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic       ex_is_load_i,
   input  logic       ex_reg_we_i,
   input  logic [4:0] ex_reg_waddr_i,
   input  logic [4:0] id_reg1_raddr_i,
   input  logic [4:0] id_reg2_raddr_i,
   output logic       load_use_o
);

   logic ex_load_wr_s;
   logic src_hit_s;

   assign ex_load_wr_s = (ex_is_load_i == LOAD_YES) && (ex_reg_we_i == WRITE_ENABLE) &&
                         (ex_reg_waddr_i != ZERO_REG);
   assign src_hit_s    = reg_match(ex_reg_waddr_i, id_reg1_raddr_i) ||
                         reg_match(ex_reg_waddr_i, id_reg2_raddr_i);
   assign load_use_o   = ex_load_wr_s && src_hit_s;

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Pipeline sequencing controller for the 5-stage RV32I core. Generates hold
// and flush controls for PC, if_id and id_ex from (in priority order) EX
// redirects, EX busy, load-use hazards and interrupt entry, and drives the
// single redirect port into PC generation.
// Optional feature macro: PIPE_CTRL_PERF_EN adds saturating stall_cnt_o and
// flush_cnt_o performance counters.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   ex_jump_flag_i / ex_jump_addr_i EX taken branch/jump and its target
//   ex_busy_i                       EX multi-cycle op in progress
//   ex_is_load_i, ex_reg_we_i, ex_reg_waddr_i  EX load / rd write info
//   id_reg1_raddr_i, id_reg2_raddr_i           decode source registers
//   id_inst_addr_i                  PC of the decode instruction
//   irq_req_i / irq_vec_i           level interrupt request and handler addr
//   irq_ack_o / irq_epc_o           handler redirect pulse and saved PC
//   hold_*_o / flush_*_o            pipeline register controls
//   jump_flag_o / jump_addr_o       PC redirect
//   stall_cnt_o / flush_cnt_o       (PIPE_CTRL_PERF_EN only)
// -----------------------------------------------------------------------------
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned IRQ_HOLDOFF = 2,
   parameter logic [31:0] RESET_VEC   = 32'h0000_0000
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_jump_flag_i,
   input  logic [31:0] ex_jump_addr_i,
   input  logic        ex_busy_i,
   input  logic        ex_is_load_i,
   input  logic        ex_reg_we_i,
   input  logic [4:0]  ex_reg_waddr_i,
   input  logic [4:0]  id_reg1_raddr_i,
   input  logic [4:0]  id_reg2_raddr_i,
   input  logic [31:0] id_inst_addr_i,
   input  logic        irq_req_i,
   input  logic [31:0] irq_vec_i,
   output logic        irq_ack_o,
   output logic [31:0] irq_epc_o,
   output logic        hold_pc_o,
   output logic        hold_if_id_o,
   output logic        hold_id_ex_o,
   output logic        flush_if_id_o,
   output logic        flush_id_ex_o,
`ifdef PIPE_CTRL_PERF_EN
   output logic [31:0] stall_cnt_o,
   output logic [31:0] flush_cnt_o,
`endif
   output logic        jump_flag_o,
   output logic [31:0] jump_addr_o
);

   localparam logic [3:0] HOLDOFF_LOAD = 4'(IRQ_HOLDOFF);

   pipe_state_e state_r, next_state_s;
   logic [31:0] epc_r;
   logic [31:0] vec_r;
   logic [31:0] last_jump_addr_r;
   logic [3:0]  holdoff_r;
   logic        load_use_s;
   logic        irq_take_s;
   logic        jump_flag_s;
   logic [31:0] jump_target_s;

   pipe_ctrl_hazard_detect u_hazard_detect (
      .ex_is_load_i    (ex_is_load_i),
      .ex_reg_we_i     (ex_reg_we_i),
      .ex_reg_waddr_i  (ex_reg_waddr_i),
      .id_reg1_raddr_i (id_reg1_raddr_i),
      .id_reg2_raddr_i (id_reg2_raddr_i),
      .load_use_o      (load_use_s)
   );

   // Control decode: priority resolution in RUN and the fixed interrupt steps.
   always_comb begin
      next_state_s  = state_r;
      irq_take_s    = 1'b0;
      jump_flag_s   = 1'b0;
      jump_target_s = last_jump_addr_r;
      hold_pc_o     = NO_HOLD;
      hold_if_id_o  = NO_HOLD;
      hold_id_ex_o  = NO_HOLD;
      flush_if_id_o = NO_FLUSH;
      flush_id_ex_o = NO_FLUSH;
      irq_ack_o     = 1'b0;
      case (state_r)
         ST_RUN: begin
            if (ex_jump_flag_i) begin
               jump_flag_s   = 1'b1;
               jump_target_s = ex_jump_addr_i;
               flush_if_id_o = FLUSH;
               flush_id_ex_o = FLUSH;
            end else if (ex_busy_i) begin
               hold_pc_o    = HOLD;
               hold_if_id_o = HOLD;
               hold_id_ex_o = HOLD;
            end else if (load_use_s) begin
               // One bubble suffices: the load leaves EX next cycle.
               hold_pc_o     = HOLD;
               hold_if_id_o  = HOLD;
               flush_id_ex_o = FLUSH;
            end else if (irq_req_i && (holdoff_r == 4'd0)) begin
               irq_take_s    = 1'b1;
               next_state_s  = ST_IRQ_ENTER;
               hold_pc_o     = HOLD;
               hold_if_id_o  = HOLD;
               flush_id_ex_o = FLUSH;
            end else begin
               next_state_s = ST_RUN;
            end
         end
         ST_IRQ_ENTER: begin
            // EX holds a bubble now, so EX-side requests cannot occur.
            next_state_s = ST_IRQ_JUMP;
            hold_pc_o    = HOLD;
            hold_if_id_o = HOLD;
         end
         ST_IRQ_JUMP: begin
            next_state_s  = ST_RUN;
            jump_flag_s   = 1'b1;
            jump_target_s = vec_r;
            flush_if_id_o = FLUSH;
            flush_id_ex_o = FLUSH;
            irq_ack_o     = 1'b1;
         end
         default: begin
            next_state_s = ST_RUN;
         end
      endcase
   end

   assign jump_flag_o = jump_flag_s;
   assign jump_addr_o = jump_target_s;
   assign irq_epc_o   = epc_r;

   // FSM state, interrupt latches, last redirect target and holdoff counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r          <= ST_RUN;
         epc_r            <= RESET_VEC;
         vec_r            <= RESET_VEC;
         last_jump_addr_r <= RESET_VEC;
         holdoff_r        <= 4'd0;
      end else begin
         state_r <= next_state_s;
         if (irq_take_s) begin
            epc_r <= id_inst_addr_i;
            vec_r <= irq_vec_i;
         end
         if (jump_flag_s) begin
            last_jump_addr_r <= jump_target_s;
         end
         if (state_r == ST_IRQ_JUMP) begin
            holdoff_r <= HOLDOFF_LOAD;
         end else if ((state_r == ST_RUN) && (holdoff_r != 4'd0)) begin
            holdoff_r <= holdoff_r - 4'd1;
         end
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cnt_r;
   logic [31:0] flush_cnt_r;

   // Saturating stall and flush event counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_r <= ZERO_WORD;
         flush_cnt_r <= ZERO_WORD;
      end else begin
         if (hold_pc_o && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
         end
         if (flush_if_id_o && (flush_cnt_r != 32'hFFFF_FFFF)) begin
            flush_cnt_r <= flush_cnt_r + 32'd1;
         end
      end
   end

   assign stall_cnt_o = stall_cnt_r;
   assign flush_cnt_o = flush_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Self-checking bench for pipe_ctrl: a table of single-cycle RUN vectors
// followed by hand-written reset, busy, interrupt and reset-mid-IRQ sequences.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

   logic        clk;
   logic        rst;
   logic        ex_jump_flag_i;
   logic [31:0] ex_jump_addr_i;
   logic        ex_busy_i;
   logic        ex_is_load_i;
   logic        ex_reg_we_i;
   logic [4:0]  ex_reg_waddr_i;
   logic [4:0]  id_reg1_raddr_i;
   logic [4:0]  id_reg2_raddr_i;
   logic [31:0] id_inst_addr_i;
   logic        irq_req_i;
   logic [31:0] irq_vec_i;
   logic        irq_ack_o;
   logic [31:0] irq_epc_o;
   logic        hold_pc_o;
   logic        hold_if_id_o;
   logic        hold_id_ex_o;
   logic        flush_if_id_o;
   logic        flush_id_ex_o;
   logic        jump_flag_o;
   logic [31:0] jump_addr_o;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cnt_o;
   logic [31:0] flush_cnt_o;
`endif

   int checks;
   int errors;

   pipe_ctrl #(.IRQ_HOLDOFF(2), .RESET_VEC(32'h0000_0000)) dut (
      .clk             (clk),
      .rst             (rst),
      .ex_jump_flag_i  (ex_jump_flag_i),
      .ex_jump_addr_i  (ex_jump_addr_i),
      .ex_busy_i       (ex_busy_i),
      .ex_is_load_i    (ex_is_load_i),
      .ex_reg_we_i     (ex_reg_we_i),
      .ex_reg_waddr_i  (ex_reg_waddr_i),
      .id_reg1_raddr_i (id_reg1_raddr_i),
      .id_reg2_raddr_i (id_reg2_raddr_i),
      .id_inst_addr_i  (id_inst_addr_i),
      .irq_req_i       (irq_req_i),
      .irq_vec_i       (irq_vec_i),
      .irq_ack_o       (irq_ack_o),
      .irq_epc_o       (irq_epc_o),
      .hold_pc_o       (hold_pc_o),
      .hold_if_id_o    (hold_if_id_o),
      .hold_id_ex_o    (hold_id_ex_o),
      .flush_if_id_o   (flush_if_id_o),
      .flush_id_ex_o   (flush_id_ex_o),
`ifdef PIPE_CTRL_PERF_EN
      .stall_cnt_o     (stall_cnt_o),
      .flush_cnt_o     (flush_cnt_o),
`endif
      .jump_flag_o     (jump_flag_o),
      .jump_addr_o     (jump_addr_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Vector: inputs plus expected {hold_pc, hold_if_id, hold_id_ex,
   // flush_if_id, flush_id_ex, jump_flag} and expected jump_addr.
   typedef struct {
      logic        jf;
      logic [31:0] ja;
      logic        busy;
      logic        ld;
      logic        we;
      logic [4:0]  wa;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic        irq;
      logic [5:0]  exp_f;
      logic [31:0] exp_ja;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [6:0] flags();
      return {hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o, flush_id_ex_o,
              jump_flag_o, irq_ack_o};
   endfunction

   task automatic idle_inputs();
      ex_jump_flag_i  = 1'b0;
      ex_jump_addr_i  = 32'hDEAD_BEEF;
      ex_busy_i       = 1'b0;
      ex_is_load_i    = 1'b0;
      ex_reg_we_i     = 1'b0;
      ex_reg_waddr_i  = 5'd0;
      id_reg1_raddr_i = 5'd0;
      id_reg2_raddr_i = 5'd0;
      irq_req_i       = 1'b0;
   endtask

   // Advance to just after the next active edge, where inputs are driven.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      idle_inputs();
      id_inst_addr_i = 32'h0000_0000;
      irq_vec_i      = 32'h0000_0000;

      vecs[0]  = '{1'b0, 32'hDEAD_0000, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 6'b000000, 32'h0000_0000};
      vecs[1]  = '{1'b0, 32'hDEAD_0001, 1'b0, 1'b1, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 6'b110010, 32'h0000_0000};
      vecs[2]  = '{1'b0, 32'hDEAD_0002, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 6'b000000, 32'h0000_0000};
      vecs[3]  = '{1'b0, 32'hDEAD_0003, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 6'b000000, 32'h0000_0000};
      vecs[4]  = '{1'b0, 32'hDEAD_0004, 1'b0, 1'b1, 1'b1, 5'd9, 5'd9, 5'd3, 1'b0, 6'b110010, 32'h0000_0000};
      vecs[5]  = '{1'b0, 32'hDEAD_0005, 1'b0, 1'b1, 1'b0, 5'd9, 5'd9, 5'd3, 1'b0, 6'b000000, 32'h0000_0000};
      vecs[6]  = '{1'b0, 32'hDEAD_0006, 1'b0, 1'b0, 1'b1, 5'd9, 5'd9, 5'd3, 1'b0, 6'b000000, 32'h0000_0000};
      vecs[7]  = '{1'b0, 32'hDEAD_0007, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 6'b111000, 32'h0000_0000};
      vecs[8]  = '{1'b1, 32'h0000_0080, 1'b1, 1'b1, 1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 6'b000111, 32'h0000_0080};
      vecs[9]  = '{1'b0, 32'hDEAD_0009, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 6'b000000, 32'h0000_0080};
      vecs[10] = '{1'b1, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 6'b000111, 32'h0000_1234};
      vecs[11] = '{1'b0, 32'hDEAD_000B, 1'b1, 1'b1, 1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 6'b111000, 32'h0000_1234};
      vecs[12] = '{1'b0, 32'hDEAD_000C, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 6'b000000, 32'h0000_1234};

      // Reset for two cycles.
      rst = 1'b1;
      step();
      @(negedge clk);
      check("reset_ack_c1", {31'd0, irq_ack_o}, 32'd0);
      step();
      @(negedge clk);
      check("reset_flags", {25'd0, flags()}, 32'd0);
      check("reset_jump_addr", jump_addr_o, 32'h0000_0000);
      check("reset_epc", irq_epc_o, 32'h0000_0000);
      rst = 1'b0;

      // Table of single-cycle RUN vectors.
      for (int i = 0; i < 13; i++) begin
         step();
         ex_jump_flag_i  = vecs[i].jf;
         ex_jump_addr_i  = vecs[i].ja;
         ex_busy_i       = vecs[i].busy;
         ex_is_load_i    = vecs[i].ld;
         ex_reg_we_i     = vecs[i].we;
         ex_reg_waddr_i  = vecs[i].wa;
         id_reg1_raddr_i = vecs[i].r1;
         id_reg2_raddr_i = vecs[i].r2;
         irq_req_i       = vecs[i].irq;
         @(negedge clk);
         check($sformatf("vec%0d_flags", i), {25'd0, flags()}, {25'd0, vecs[i].exp_f, 1'b0});
         check($sformatf("vec%0d_jump_addr", i), jump_addr_o, vecs[i].exp_ja);
      end

      // Busy for three cycles, then resume.
      for (int c = 0; c < 4; c++) begin
         step();
         idle_inputs();
         ex_busy_i = (c < 3);
         @(negedge clk);
         check($sformatf("busy_c%0d", c), {25'd0, flags()}, (c < 3) ? 32'h70 : 32'h0);
      end

      // Interrupt entry, redirect, holdoff and re-entry.
      step();
      irq_req_i      = 1'b1;
      id_inst_addr_i = 32'h0000_0100;
      irq_vec_i      = 32'h0000_0200;
      @(negedge clk);
      check("irq_accept_flags", {25'd0, flags()}, 32'h64);
      step();
      id_inst_addr_i = 32'h0000_0104;
      irq_vec_i      = 32'h0000_0300;
      @(negedge clk);
      check("irq_enter_flags", {25'd0, flags()}, 32'h60);
      check("irq_epc", irq_epc_o, 32'h0000_0100);
      step();
      @(negedge clk);
      check("irq_jump_flags", {25'd0, flags()}, 32'h0F);
      check("irq_jump_addr", jump_addr_o, 32'h0000_0200);
      for (int c = 0; c < 2; c++) begin
         step();
         @(negedge clk);
         check($sformatf("holdoff_c%0d", c), {25'd0, flags()}, 32'h0);
         check($sformatf("holdoff_addr_c%0d", c), jump_addr_o, 32'h0000_0200);
      end
      step();
      id_inst_addr_i = 32'h0000_0108;
      @(negedge clk);
      check("reentry_flags", {25'd0, flags()}, 32'h64);
      step();
      irq_req_i = 1'b0;
      @(negedge clk);
      check("reentry_epc", irq_epc_o, 32'h0000_0108);
      step();
      @(negedge clk);
      check("reentry_jump_addr", jump_addr_o, 32'h0000_0300);
      check("reentry_ack", {31'd0, irq_ack_o}, 32'd1);

      // Let holdoff expire, enter again and reset in IRQ_ENTER.
      step();
      step();
      step();
      irq_req_i      = 1'b1;
      id_inst_addr_i = 32'h0000_0400;
      irq_vec_i      = 32'h0000_0500;
      @(negedge clk);
      check("rst_seq_accept", {25'd0, flags()}, 32'h64);
      step();
      rst       = 1'b1;
      irq_req_i = 1'b0;
      @(negedge clk);
      check("rst_seq_enter", {25'd0, flags()}, 32'h60);
      step();
      rst = 1'b0;
      @(negedge clk);
      check("rst_seq_flags", {25'd0, flags()}, 32'h0);
      check("rst_seq_epc", irq_epc_o, 32'h0000_0000);
      check("rst_seq_jump_addr", jump_addr_o, 32'h0000_0000);
      step();
      @(negedge clk);
      check("rst_seq_no_ack", {25'd0, flags()}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RV32I core. It generates the hold and flush controls for the PC, if_id and id_ex registers from four sources, in priority order: EX redirects (ex_jump), multi-cycle EX busy, load-use hazards against the operands being decoded, and external interrupt entry. It owns a small FSM that drains and redirects the pipeline on interrupt, and it drives the single jump/redirect port into PC generation.

Parameters:
IRQ_HOLDOFF, 2, cycles after an interrupt redirect during which irq_req_i is ignored (0..15).
RESET_VEC, 32'h0000_0000, value of jump_addr_o and irq_epc_o after reset.

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
ex_jump_flag_i  in  1  EX resolved a taken branch/jump
ex_jump_addr_i  in  32  EX redirect target
ex_busy_i  in  1  EX multi-cycle op in progress
ex_is_load_i  in  1  instruction in EX is LB/LH/LW/LBU/LHU
ex_reg_we_i  in  1  EX instruction writes rd
ex_reg_waddr_i  in  5  EX rd
id_reg1_raddr_i  in  5  rs1 being read by decode (0 = none)
id_reg2_raddr_i  in  5  rs2 being read by decode (0 = none)
id_inst_addr_i  in  32  PC of the instruction in decode
irq_req_i  in  1  level interrupt request
irq_vec_i  in  32  handler address, sampled at entry
irq_ack_o  out  1  one-cycle pulse on redirect to the handler
irq_epc_o  out  32  PC of the squashed decode instruction (to CSR mepc)
hold_pc_o  out  1  freeze PC
hold_if_id_o  out  1  freeze if_id
hold_id_ex_o  out  1  freeze id_ex
flush_if_id_o  out  1  if_id loads NOP
flush_id_ex_o  out  1  id_ex loads bubble
jump_flag_o  out  1  redirect PC this cycle
jump_addr_o  out  32  redirect target

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- On reset, all 1-bit outputs are 0, jump_addr_o and irq_epc_o equal RESET_VEC, FSM is RUN, holdoff counter is 0.
- FSM states:
  - RUN: normal operation.
  - IRQ_ENTER: one cycle. The decode instruction is squashed and epc is captured.
  - IRQ_JUMP: one cycle. Redirect to the handler.
- Control outputs are combinational from state and inputs; epc, the vector latch and the holdoff counter are registered.
- RUN, evaluated in priority order, first match wins:
  1. ex_jump_flag_i: jump_flag_o=1, jump_addr_o=ex_jump_addr_i, flush_if_id_o=1, flush_id_ex_o=1. Busy, load-use and irq are all ignored this cycle.
  2. ex_busy_i: hold_pc_o=1, hold_if_id_o=1, hold_id_ex_o=1, no flush.
  3. Load-use hazard: holds when ex_is_load_i & ex_reg_we_i & ex_reg_waddr_i!=0 and ex_reg_waddr_i equals a nonzero id_reg1_raddr_i or id_reg2_raddr_i. Response is hold_pc_o=1, hold_if_id_o=1, flush_id_ex_o=1. This gives exactly one bubble, because the load leaves EX next cycle.
  4. irq_req_i & holdoff==0: go to IRQ_ENTER. Latch irq_epc_o=id_inst_addr_i and the vector from irq_vec_i. Outputs are hold_pc_o=1, hold_if_id_o=1, flush_id_ex_o=1.
- IRQ_ENTER → IRQ_JUMP unconditionally. EX now contains a bubble, so ex_jump/ex_busy/load-use cannot assert and are ignored. Outputs are hold_pc_o=1, hold_if_id_o=1.
- IRQ_JUMP → RUN. Outputs are jump_flag_o=1, jump_addr_o=latched vector, flush_if_id_o=1, flush_id_ex_o=1, irq_ack_o=1. Holdoff counter loads IRQ_HOLDOFF.
- Holdoff counter decrements in RUN while nonzero and saturates at 0. irq_req_i is masked while it is nonzero.
- Interrupt latency is 2 cycles from acceptance to handler fetch.
- jump_addr_o holds its last value when jump_flag_o=0.
- A hold and a flush on the same register never assert together; flush wins by construction.
- rst mid-IRQ sequence: returns to RUN with no ack pulse.

Optional Feature:
PIPE_CTRL_PERF_EN. When defined, adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0], both saturating and cleared by rst.
- stall_cnt_o counts cycles with hold_pc_o=1.
- flush_cnt_o counts cycles with flush_if_id_o=1.
When undefined, neither port nor the counters exist, and the remaining behaviour is identical.

Decomposition:
- Shared defines header: state encodings, `ZeroReg, `ZeroWord, `WriteEnable/`WriteDisable, `Hold/`NoHold and `Flush levels, and the load-opcode indication constants.
- Natural sub-module: hazard_detect, holding the combinational load-use compare and instantiated once. The FSM and counters stay in pipe_ctrl.

Test Plan:
1. Reset with rst=1 for 2 cycles → all flags 0, jump_addr_o=irq_epc_o=RESET_VEC, irq_ack_o stays 0.
2. Load-use: ex_is_load_i=1, we=1, waddr=5, id_reg2_raddr_i=5 → exactly one cycle of hold_pc/hold_if_id/flush_id_ex. With waddr=0, or only rs1=0 matching → no stall.
3. Priority: ex_jump_flag_i=1, ex_busy_i=1, hazard and irq all together with ex_jump_addr_i=32'h80 → jump_flag_o=1, jump_addr_o=32'h80, both flushes, no hold, FSM stays RUN.
4. ex_busy_i=1 for 3 cycles → all three holds for 3 cycles, no flush; resumes the cycle busy drops.
5. irq_req_i=1, id_inst_addr_i=32'h100, irq_vec_i=32'h200 → irq_epc_o=32'h100. Redirect to 32'h200 two cycles later with a single-cycle irq_ack_o. irq_req_i still high is then ignored for exactly IRQ_HOLDOFF=2 cycles, and re-entry occurs on the 3rd.
6. rst asserted in IRQ_ENTER → next cycle is RUN with all outputs at reset values and no ack.
